// File: rtl/board_input_conditioner.sv
// Board reset/button conditioner: lock-gated power-up delay, long-press
// reset, debounced buttons with edge pulses and a heartbeat LED.
module board_input_conditioner #(
  parameter int unsigned NUM_BUTTONS = 4,
  parameter logic [NUM_BUTTONS-1:0] BTN_ACTIVE_LOW = 4'b0001,
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned POWERUP_CYCLES = 512,
  parameter int unsigned RESET_BTN = 0,
  parameter int unsigned LONG_PRESS_CYCLES = 25200000,
  parameter int unsigned HEARTBEAT_CYCLES = 25200000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pll_locked,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_pressed,
  output logic [NUM_BUTTONS-1:0] btn_released,
  output logic                   sys_reset,
  output logic                   rst_n,
  output logic                   heartbeat
);

  localparam int unsigned DB_W =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PU_W =
    (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
  localparam int unsigned LP_W =
    (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam int unsigned HB_W =
    (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PU_W-1:0] PU_LAST = PU_W'(POWERUP_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);
  localparam logic [NUM_BUTTONS-1:0] RB_MASK =
    NUM_BUTTONS'(1) << RESET_BTN;

  typedef enum logic [1:0] {
    ST_POWERUP,
    ST_RUN,
    ST_LONGPRESS
  } state_e;

  logic [NUM_BUTTONS-1:0] bs1_q, bs2_q, btn_sync;
  logic [NUM_BUTTONS-1:0] stable_q, pressed_q, released_q;
  logic [DB_W-1:0]        db_cnt_q [NUM_BUTTONS];
  logic                   ls1_q, ls2_q;
  state_e                 state_q;
  logic [PU_W-1:0]        pu_cnt_q;
  logic [LP_W-1:0]        hold_cnt_q;
  logic                   sys_reset_q, rst_n_q;
  logic [HB_W-1:0]        hb_cnt_q, hb_cnt_d;
  logic                   hb_q, hb_d;
  logic                   rst_btn;

  assign btn_sync = bs2_q ^ BTN_ACTIVE_LOW;
  assign rst_btn  = |(stable_q & RB_MASK);

  always_ff @(posedge clk) begin
    if (reset) begin
      bs1_q      <= '0;
      bs2_q      <= '0;
      stable_q   <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      bs1_q <= btn_raw;
      bs2_q <= bs1_q;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        pressed_q[i]  <= 1'b0;
        released_q[i] <= 1'b0;
        if (btn_sync[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_cnt_q[i]   <= '0;
          stable_q[i]   <= btn_sync[i];
          pressed_q[i]  <= btn_sync[i];
          released_q[i] <= ~btn_sync[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Reset asserts on the edge that leaves RUN; release lags RUN entry by one.
  always_ff @(posedge clk) begin
    if (reset) begin
      ls1_q       <= 1'b0;
      ls2_q       <= 1'b0;
      state_q     <= ST_POWERUP;
      pu_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      sys_reset_q <= 1'b1;
      rst_n_q     <= 1'b0;
    end else begin
      ls1_q <= pll_locked;
      ls2_q <= ls1_q;
      unique case (state_q)
        ST_POWERUP: begin
          sys_reset_q <= 1'b1;
          rst_n_q     <= 1'b0;
          if (!ls2_q) begin
            pu_cnt_q <= '0;
          end else if (pu_cnt_q == PU_LAST) begin
            pu_cnt_q   <= '0;
            hold_cnt_q <= '0;
            state_q    <= ST_RUN;
          end else begin
            pu_cnt_q <= pu_cnt_q + PU_W'(1);
          end
        end
        ST_RUN: begin
          if (!ls2_q) begin
            hold_cnt_q  <= '0;
            state_q     <= ST_POWERUP;
            sys_reset_q <= 1'b1;
            rst_n_q     <= 1'b0;
          end else if (!rst_btn) begin
            hold_cnt_q  <= '0;
            sys_reset_q <= 1'b0;
            rst_n_q     <= 1'b1;
          end else if (hold_cnt_q == LP_LAST) begin
            hold_cnt_q  <= '0;
            state_q     <= ST_LONGPRESS;
            sys_reset_q <= 1'b1;
            rst_n_q     <= 1'b0;
          end else begin
            hold_cnt_q  <= hold_cnt_q + LP_W'(1);
            sys_reset_q <= 1'b0;
            rst_n_q     <= 1'b1;
          end
        end
        ST_LONGPRESS: begin
          sys_reset_q <= 1'b1;
          rst_n_q     <= 1'b0;
          if (!ls2_q || !rst_btn) begin
            pu_cnt_q <= '0;
            state_q  <= ST_POWERUP;
          end
        end
        default: begin
          state_q     <= ST_POWERUP;
          sys_reset_q <= 1'b1;
          rst_n_q     <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    hb_cnt_d = hb_cnt_q + HB_W'(1);
    hb_d     = hb_q;
    if (hb_cnt_q == HB_LAST) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
    end
  end

  assign btn_level    = stable_q;
  assign btn_pressed  = pressed_q;
  assign btn_released = released_q;
  assign sys_reset    = sys_reset_q;
  assign rst_n        = rst_n_q;
  assign heartbeat    = hb_q;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Bench for board_input_conditioner: directed timing scenarios plus
// randomized traffic against a run-length reference model.
module tb_board_input_conditioner;

  localparam int NB = 4;
  localparam logic [3:0] MASK = 4'b0001;
  localparam int D = 4;
  localparam int P = 8;
  localparam int L = 16;
  localparam int H = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pll_locked = 1'b0;
  logic [3:0] btn_raw = 4'b0001;
  logic [3:0] btn_level, btn_pressed, btn_released;
  logic sys_reset, rst_n, heartbeat;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  board_input_conditioner #(
    .NUM_BUTTONS(NB),
    .BTN_ACTIVE_LOW(MASK),
    .DEBOUNCE_CYCLES(D),
    .POWERUP_CYCLES(P),
    .RESET_BTN(0),
    .LONG_PRESS_CYCLES(L),
    .HEARTBEAT_CYCLES(H)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pll_locked(pll_locked),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_pressed(btn_pressed),
    .btn_released(btn_released),
    .sys_reset(sys_reset),
    .rst_n(rst_n),
    .heartbeat(heartbeat)
  );

  // Reference model: run lengths of synchronised inputs per edge.
  logic [3:0] m_s1 = '0, m_s2 = '0;
  logic [3:0] m_lvl = '0, m_pr = '0, m_rl = '0;
  logic m_l1 = 0, m_l2 = 0;
  logic m_up = 0, m_was_up = 0, m_wait = 0;
  logic m_sysrst = 1, m_hb = 0;
  int m_run [4] = '{0, 0, 0, 0};
  int m_lock_run = 0, m_hold_run = 0;
  int unsigned m_n = 0;

  function automatic void model_step();
    logic [3:0] now_pressed;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_l1 = 0; m_l2 = 0;
      m_lvl = '0; m_pr = '0; m_rl = '0;
      m_up = 0; m_was_up = 0; m_wait = 0;
      m_lock_run = 0; m_hold_run = 0; m_n = 0;
      for (int b = 0; b < 4; b++) m_run[b] = 0;
      m_sysrst = 1; m_hb = 0;
      return;
    end
    m_n++;
    now_pressed = m_s2 ^ MASK;
    m_was_up = m_up;
    if (!m_l2) begin
      m_up = 0; m_wait = 0; m_lock_run = 0; m_hold_run = 0;
    end else if (m_wait) begin
      if (!m_lvl[0]) begin m_wait = 0; m_lock_run = 0; end
    end else if (!m_up) begin
      m_lock_run++;
      if (m_lock_run == P) begin
        m_up = 1; m_lock_run = 0; m_hold_run = 0;
      end
    end else if (m_lvl[0]) begin
      m_hold_run++;
      if (m_hold_run == L) begin
        m_up = 0; m_wait = 1; m_hold_run = 0;
      end
    end else begin
      m_hold_run = 0;
    end
    m_sysrst = !(m_up && m_was_up);
    for (int b = 0; b < 4; b++) begin
      m_pr[b] = 0;
      m_rl[b] = 0;
      if (now_pressed[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == D) begin
          m_lvl[b] = now_pressed[b];
          m_pr[b] = now_pressed[b];
          m_rl[b] = !now_pressed[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_s2 = m_s1; m_s1 = btn_raw;
    m_l2 = m_l1; m_l1 = pll_locked;
    m_hb = ((m_n / H) % 2) == 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pll_locked = 1'b1;
    btn_raw = MASK;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({sys_reset, rst_n, heartbeat, btn_level, btn_pressed, btn_released}
          !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
        errs++;
        $display("FAIL reset_state: got sr=%b rn=%b hb=%b lvl=%h pr=%h rl=%h, want 1 0 0 0 0 0",
                 sys_reset, rst_n, heartbeat, btn_level, btn_pressed, btn_released);
      end
    end
  endtask

  task automatic test_powerup();
    int fall, tog1, tog2;
    fall = -1; tog1 = -1; tog2 = -1;
    reset = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      tick();
      checks++;
      if (sys_reset !== m_sysrst || rst_n !== ~m_sysrst || heartbeat !== m_hb) begin
        errs++;
        $display("FAIL powerup_model e=%0d: got sr=%b rn=%b hb=%b, want sr=%b hb=%b",
                 e, sys_reset, rst_n, heartbeat, m_sysrst, m_hb);
      end
      if (fall < 0 && sys_reset === 1'b0) fall = e;
      if (tog1 < 0 && heartbeat === 1'b1) tog1 = e;
      if (tog1 > 0 && tog2 < 0 && heartbeat === 1'b0) tog2 = e;
    end
    checks++;
    if (fall != P + 3) begin
      errs++;
      $display("FAIL powerup_release: sys_reset fell at edge %0d, want %0d", fall, P + 3);
    end
    checks++;
    if (tog1 != H || tog2 != 2 * H) begin
      errs++;
      $display("FAIL heartbeat_period: toggles at %0d,%0d, want %0d,%0d", tog1, tog2, H, 2 * H);
    end
  endtask

  task automatic test_debounce();
    int rise, drop;
    bit bad;
    rise = -1; drop = -1; bad = 0;
    btn_raw[1] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if ({btn_level, btn_pressed, btn_released} !== {m_lvl, m_pr, m_rl}) begin
        errs++;
        $display("FAIL debounce_model e=%0d: got %h/%h/%h, want %h/%h/%h",
                 e, btn_level, btn_pressed, btn_released, m_lvl, m_pr, m_rl);
      end
      if (rise < 0 && btn_level[1] === 1'b1) begin
        rise = e;
        checks++;
        if (btn_pressed[1] !== 1'b1) begin
          errs++;
          $display("FAIL press_pulse: got %b, want 1", btn_pressed[1]);
        end
      end else if (rise > 0 && e == rise + 1) begin
        checks++;
        if (btn_pressed[1] !== 1'b0) begin
          errs++;
          $display("FAIL press_width: got %b, want 0", btn_pressed[1]);
        end
      end
    end
    checks++;
    if (rise != D + 2) begin
      errs++;
      $display("FAIL press_latency: got edge %0d, want %0d", rise, D + 2);
    end
    btn_raw[1] = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      if (e == 4) btn_raw[1] = 1'b1;
      tick();
      if (btn_level[1] !== 1'b1 || btn_released[1] !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errs++;
      $display("FAIL glitch_reject: level=%b released=%b, want 1 0", btn_level[1], btn_released[1]);
    end
    btn_raw[1] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (drop < 0 && btn_released[1] === 1'b1) begin
        drop = e;
        checks++;
        if (btn_level[1] !== 1'b0 || btn_pressed[1] !== 1'b0) begin
          errs++;
          $display("FAIL release_level: level=%b pressed=%b, want 0 0", btn_level[1], btn_pressed[1]);
        end
      end
    end
    checks++;
    if (drop != D + 2) begin
      errs++;
      $display("FAIL release_latency: got edge %0d, want %0d", drop, D + 2);
    end
  endtask

  task automatic test_active_low();
    int rise, fall;
    bit bad;
    rise = -1; fall = -1; bad = 0;
    btn_raw[0] = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (sys_reset !== 1'b0) bad = 1;
      if (rise < 0 && btn_level[0] === 1'b1) begin
        rise = e;
        btn_raw[0] = 1'b1;
      end else if (rise > 0 && fall < 0 && btn_level[0] === 1'b0) begin
        fall = e;
      end
    end
    checks++;
    if (rise != D + 2) begin
      errs++;
      $display("FAIL active_low_latency: got edge %0d, want %0d", rise, D + 2);
    end
    checks++;
    if (bad || fall != rise + D + 2) begin
      errs++;
      $display("FAIL active_low_release: fall=%0d sys_reset_seen=%b, want fall=%0d no reset",
               fall, bad, rise + D + 2);
    end
  endtask

  task automatic test_long_press();
    int lr, rr, lf, rf;
    bit held_ok, bad;
    lr = -1; rr = -1; lf = -1; rf = -1; held_ok = 1; bad = 0;
    btn_raw[0] = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      checks++;
      if (sys_reset !== m_sysrst || btn_level !== m_lvl) begin
        errs++;
        $display("FAIL longpress_model e=%0d: sr=%b lvl=%h, want sr=%b lvl=%h",
                 e, sys_reset, btn_level, m_sysrst, m_lvl);
      end
      if (lr < 0 && btn_level[0] === 1'b1) lr = e;
      if (rr < 0 && sys_reset === 1'b1) rr = e;
    end
    checks++;
    if (lr < 0 || rr - lr != L) begin
      errs++;
      $display("FAIL longpress_delay: level at %0d, reset at %0d, want gap %0d", lr, rr, L);
    end
    btn_raw[0] = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      checks++;
      if (sys_reset !== m_sysrst || rst_n !== ~m_sysrst) begin
        errs++;
        $display("FAIL longpress_release_model e=%0d: sr=%b rn=%b, want sr=%b",
                 e, sys_reset, rst_n, m_sysrst);
      end
      if (lf < 0 && sys_reset !== 1'b1) held_ok = 0;
      if (lf < 0 && btn_level[0] === 1'b0) lf = e;
      else if (lf > 0 && rf < 0 && sys_reset === 1'b0) rf = e;
    end
    checks++;
    if (!held_ok || lf != D + 2 || rf < 0) begin
      errs++;
      $display("FAIL longpress_hold: held=%b level_fall=%0d reset_fall=%0d, want 1 %0d >0",
               held_ok, lf, rf, D + 2);
    end
    btn_raw[0] = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      if (e == 11) btn_raw[0] = 1'b1;
      tick();
      if (sys_reset !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errs++;
      $display("FAIL short_hold: sys_reset asserted, want 0");
    end
  endtask

  task automatic test_lock_loss();
    int rise, fall;
    rise = -1; fall = -1;
    pll_locked = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 2) pll_locked = 1'b1;
      checks++;
      if (sys_reset !== m_sysrst || rst_n !== ~m_sysrst) begin
        errs++;
        $display("FAIL lock_model e=%0d: sr=%b rn=%b, want sr=%b", e, sys_reset, rst_n, m_sysrst);
      end
      if (rise < 0 && sys_reset === 1'b1) rise = e;
      else if (rise > 0 && fall < 0 && sys_reset === 1'b0) fall = e;
    end
    checks++;
    if (rise != 3) begin
      errs++;
      $display("FAIL lock_loss_assert: got edge %0d, want 3", rise);
    end
    checks++;
    if (fall != 2 + P + 3) begin
      errs++;
      $display("FAIL lock_return_release: got edge %0d, want %0d", fall, 2 + P + 3);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    bad = 0;
    btn_raw[0] = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 12) btn_raw[1] = 1'b1;
    end
    checks++;
    if (sys_reset !== 1'b0 || btn_level[1:0] !== 2'b01) begin
      errs++;
      $display("FAIL reset_mid_pre: sr=%b lvl=%b, want 0 01", sys_reset, btn_level[1:0]);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({sys_reset, rst_n, heartbeat, btn_level, btn_pressed, btn_released}
        !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
      errs++;
      $display("FAIL reset_mid: got sr=%b rn=%b hb=%b lvl=%h pr=%h rl=%h, want 1 0 0 0 0 0",
               sys_reset, rst_n, heartbeat, btn_level, btn_pressed, btn_released);
    end
    btn_raw = MASK;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (btn_pressed !== 4'h0 || btn_released !== 4'h0) bad = 1;
      checks++;
      if ({sys_reset, heartbeat, btn_level} !== {m_sysrst, m_hb, m_lvl}) begin
        errs++;
        $display("FAIL reset_mid_model e=%0d: sr=%b hb=%b lvl=%h, want %b %b %h",
                 e, sys_reset, heartbeat, btn_level, m_sysrst, m_hb, m_lvl);
      end
    end
    checks++;
    if (bad) begin
      errs++;
      $display("FAIL stale_pulse: pulse seen after reset, want none");
    end
  endtask

  task automatic test_random();
    int down, k;
    down = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, 3);
        btn_raw[k] = ~btn_raw[k];
      end
      if (down > 0) begin
        down--;
        if (down == 0) pll_locked = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        pll_locked = 1'b0;
        down = $urandom_range(1, 4);
      end
      reset = ($urandom_range(0, 599) == 0);
      tick();
      checks++;
      if ({sys_reset, rst_n, heartbeat, btn_level, btn_pressed, btn_released}
          !== {m_sysrst, ~m_sysrst, m_hb, m_lvl, m_pr, m_rl}) begin
        errs++;
        $display("FAIL random_model c=%0d: sr=%b rn=%b hb=%b lvl=%h pr=%h rl=%h, want %b %b %h %h %h",
                 c, sys_reset, rst_n, heartbeat, btn_level, btn_pressed, btn_released,
                 m_sysrst, m_hb, m_lvl, m_pr, m_rl);
      end
      checks++;
      if ((btn_pressed & btn_released) !== 4'h0) begin
        errs++;
        $display("FAIL pulse_exclusive c=%0d: pr=%h rl=%h, want disjoint", c, btn_pressed, btn_released);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_debounce();
    test_active_low();
    test_long_press();
    test_lock_loss();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
